// File: rtl/seq_alu.sv
// Sequential ALU stage behind a 2-level operand stack: one op per Start, result pushed back via a PE pulse.
// ADD/SUB/logic resolve in one CALC cycle; MUL/DIV/MOD iterate W cycles over a shared 2W-bit work register.
module seq_alu #(
  parameter int W    = 8,
  parameter int CNTW = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] TDP,
  input  logic [W-1:0] PDP,
  input  logic [2:0]   Op,
  input  logic         Start,
  output logic [W-1:0] D,
  output logic         PE,
  output logic         Busy,
  output logic         Z,
  output logic         C,
  output logic         Err
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  state_t state, state_nxt;

  logic [W-1:0]    a_reg, b_reg;
  logic [2:0]      op_reg;
  logic [CNTW-1:0] cnt;
  logic [2*W-1:0]  p;

  logic            is_div, is_iter, div_zero, last;
  logic [W:0]      add_r, mul_sum, r_sh;
  logic            ge;
  logic [2*W-1:0]  mul_next, div_next, step_p;
  logic [W-1:0]    alu_res, iter_res;
  logic            alu_cy, iter_cy;

  always_comb begin
    is_div   = (op_reg == OP_DIV) || (op_reg == OP_MOD);
    is_iter  = is_div || (op_reg == OP_MUL);
    div_zero = is_div && (b_reg == '0);
    last     = (cnt == CNTW'(W-1));
  end

  // MUL: p = {acc_hi, multiplier}; DIV/MOD: p = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a_reg} : '0);
    mul_next = {mul_sum, p[W-1:1]};
    r_sh     = {p[2*W-1:W], p[W-1]};
    ge       = (r_sh >= {1'b0, b_reg});
    div_next = {(ge ? (r_sh[W-1:0] - b_reg) : r_sh[W-1:0]), p[W-2:0], ge};
    step_p   = (op_reg == OP_MUL) ? mul_next : div_next;
  end

  always_comb begin
    add_r    = {1'b0, a_reg} + {1'b0, b_reg};
    alu_res  = '0;
    alu_cy   = 1'b0;
    iter_res = '0;
    iter_cy  = 1'b0;
    case (op_reg)
      OP_ADD: begin alu_res = add_r[W-1:0]; alu_cy = add_r[W]; end
      OP_SUB: begin alu_res = a_reg - b_reg; alu_cy = (a_reg < b_reg); end
      OP_AND: alu_res = a_reg & b_reg;
      OP_OR:  alu_res = a_reg | b_reg;
      OP_XOR: alu_res = a_reg ^ b_reg;
      OP_MUL: begin iter_res = mul_next[W-1:0]; iter_cy = |mul_next[2*W-1:W]; end
      OP_DIV: iter_res = div_next[W-1:0];
      OP_MOD: iter_res = div_next[2*W-1:W];
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    PE        = 1'b0;
    case (state)
      IDLE: if (Start) state_nxt = CALC;
      CALC: begin
        Busy = 1'b1;
        if (!is_iter || div_zero || last) state_nxt = DONE;
      end
      DONE: begin
        Busy      = 1'b1;
        PE        = ~Err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      cnt    <= '0;
      p      <= '0;
      D      <= '0;
      Z      <= 1'b0;
      C      <= 1'b0;
      Err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          a_reg  <= PDP;
          b_reg  <= TDP;
          op_reg <= Op;
          cnt    <= '0;
          Err    <= 1'b0;
          p      <= (Op == OP_MUL) ? {{W{1'b0}}, TDP} : {{W{1'b0}}, PDP};
        end
        CALC: begin
          if (!is_iter) begin
            D <= alu_res;
            C <= alu_cy;
            Z <= (alu_res == '0);
          end else if (div_zero) begin
            D   <= '1;
            C   <= 1'b0;
            Z   <= 1'b0;
            Err <= 1'b1;
          end else begin
            p   <= step_p;
            cnt <= cnt + 1'b1;
            if (last) begin
              D <= iter_res;
              C <= iter_cy;
              Z <= (iter_res == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [W-1:0] TDP, PDP, D;
  logic [2:0]   Op;
  logic         Start, PE, Busy, Z, C, Err;

  int n_checks = 0;
  int n_pass   = 0;
  int pe_count = 0;

  always #5 Clk = ~Clk;

  seq_alu #(.W(W), .CNTW(3)) dut (
    .Clk(Clk), .Reset(Reset), .TDP(TDP), .PDP(PDP), .Op(Op), .Start(Start),
    .D(D), .PE(PE), .Busy(Busy), .Z(Z), .C(C), .Err(Err)
  );

  always @(posedge Clk) if (PE) pe_count <= pe_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic c, output logic z,
                       output logic e, output int lat);
    int ia, ib, r, mask;
    mask = (1 << W) - 1;
    ia = int'(a);
    ib = int'(b);
    r = 0; c = 1'b0; e = 1'b0; lat = 1;
    case (op)
      3'd0: begin r = ia + ib; c = (r > mask); end
      3'd1: begin r = ia - ib; c = (ia < ib); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: begin r = ia * ib; c = (r > mask); lat = W; end
      default: begin
        if (ib == 0) begin r = mask; e = 1'b1; end
        else begin r = (op == 3'd6) ? ia / ib : ia % ib; lat = W; end
      end
    endcase
    d = W'(r & mask);
    z = (d == '0) && !e;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    logic [W-1:0] ed;
    logic ec, ez, ee;
    int el, cyc, pe0;
    bit done;
    model(op, a, b, ed, ec, ez, ee, el);
    pe0 = pe_count;
    Op = op; PDP = a; TDP = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    PDP = W'($urandom); TDP = W'($urandom); Op = 3'($urandom);
    check("busy_on_start", Busy, 1);
    check("err_cleared", Err, 0);
    done = 0;
    cyc = 0;
    while (cyc < W + 4) begin
      cyc++;
      @(posedge Clk); #1;
      if (Busy && (PE || Err)) begin done = 1; break; end
      Start = poke && (cyc == 2);
    end
    Start = 1'b0;
    check("done_seen", done, 1);
    if (done) begin
      check("latency", cyc, el);
      check("d", D, ed);
      check("c", C, ec);
      check("z", Z, ez);
      check("err", Err, ee);
      check("pe", PE, !ee);
    end
    @(posedge Clk); #1;
    check("idle_busy", Busy, 0);
    check("idle_pe", PE, 0);
    check("d_hold", D, ed);
    check("pe_pulses", pe_count - pe0, ee ? 0 : 1);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Op = '0; PDP = '0; TDP = '0;
    #2 Reset = 1'b1;
    #1;
    check("rst_d", D, 0);
    check("rst_flags", {PE, Busy, Z, C, Err}, 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    run_op(3'd0, 8'd200, 8'd100, 0);
    run_op(3'd1, 8'd5,   8'd7,   0);
    run_op(3'd1, 8'd7,   8'd7,   0);
    run_op(3'd5, 8'd20,  8'd13,  0);
    run_op(3'd5, 8'd15,  8'd17,  0);
    run_op(3'd6, 8'd100, 8'd7,   0);
    run_op(3'd7, 8'd100, 8'd7,   0);
    run_op(3'd6, 8'd9,   8'd0,   0);
    run_op(3'd2, 8'hF0,  8'h3C,  0);
    run_op(3'd5, 8'd255, 8'd255, 1);
    run_op(3'd7, 8'd255, 8'd1,   0);

    // Start held high across DONE launches a second op on the first IDLE edge.
    Op = 3'd0; PDP = 8'd1; TDP = 8'd2; Start = 1'b1;
    @(posedge Clk); #1;
    check("hold_busy", Busy, 1);
    @(posedge Clk); #1;
    check("hold_d1", D, 3);
    check("hold_pe1", PE, 1);
    PDP = 8'd10; TDP = 8'd20;
    @(posedge Clk); #1;
    check("hold_idle", Busy, 0);
    @(posedge Clk); #1;
    check("hold_restart", Busy, 1);
    Start = 1'b0;
    @(posedge Clk); #1;
    check("hold_d2", D, 30);
    check("hold_pe2", PE, 1);
    @(posedge Clk); #1;

    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = 3'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 8'hFF : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
      run_op(op, a, b, (op == 3'd5) && ($urandom_range(0, 1) == 1));
    end

    // Reset in the middle of a MUL aborts it with no push.
    run_op(3'd0, 8'd200, 8'd100, 0);
    begin
      int pe0;
      pe0 = pe_count;
      Op = 3'd5; PDP = 8'd20; TDP = 8'd13; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (4) @(posedge Clk);
      #1 Reset = 1'b1;
      #1;
      check("abort_d", D, 0);
      check("abort_flags", {PE, Busy, Z, C, Err}, 0);
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      repeat (12) @(posedge Clk);
      #1;
      check("abort_no_pe", pe_count - pe0, 0);
      check("abort_busy", Busy, 0);
      check("abort_d_after", D, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
